// File: rtl/atuador_valvula_agua_if.sv
// rtl/atuador_valvula_agua_if.sv - request/limit-switch inputs and drive/status outputs of the valve actuator
interface atuador_valvula_agua_if;
    logic       S_req;
    logic       fim_curso;
    logic       valvula;
    logic       aberta;
    logic       falha;
    logic [1:0] estado;

    modport master (
        output S_req,
        output fim_curso,
        input  valvula,
        input  aberta,
        input  falha,
        input  estado
    );

    modport slave (
        input  S_req,
        input  fim_curso,
        output valvula,
        output aberta,
        output falha,
        output estado
    );
endinterface

// File: rtl/atuador_valvula_agua.sv
// rtl/atuador_valvula_agua.sv - debounced valve actuator FSM with open timeout, minimum on-time and fault latch
// Optional macro AUTO_REARME_EN: FALHA returns to FECHADA once the filtered request is low.
module atuador_valvula_agua #(
    parameter int DEB_CYCLES   = 4,
    parameter int OPEN_TIMEOUT = 16,
    parameter int MIN_ON       = 8,
    parameter int CW           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    atuador_valvula_agua_if.slave  bus
);
    typedef enum logic [1:0] {
        FECHADA = 2'b00,
        ABRINDO = 2'b01,
        ABERTA  = 2'b10,
        FALHA   = 2'b11
    } state_t;

    localparam logic [CW-1:0] L_DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] L_TO_LAST  = CW'(OPEN_TIMEOUT - 1);
    localparam logic [CW-1:0] L_MIN_ON   = CW'(MIN_ON);

    state_t        r_state;
    logic          r_req_f;
    logic [CW-1:0] r_deb_cnt;
    logic [CW-1:0] r_timer;

    // Filtered request only follows S_req after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_f   <= 1'b0;
            r_deb_cnt <= '0;
        end else if (bus.S_req == r_req_f) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == L_DEB_LAST) begin
            r_req_f   <= bus.S_req;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FECHADA;
            r_timer <= '0;
        end else begin
            case (r_state)
                FECHADA: begin
                    if (r_req_f) begin
                        r_state <= ABRINDO;
                        r_timer <= '0;
                    end
                end
                ABRINDO: begin
                    if (!r_req_f) begin
                        r_state <= FECHADA;
                    end else if (bus.fim_curso) begin
                        r_state <= ABERTA;
                        r_timer <= '0;
                    end else if (r_timer == L_TO_LAST) begin
                        r_state <= FALHA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ABERTA: begin
                    if (r_timer != L_MIN_ON) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // Losing the limit switch outranks a legitimate close.
                    if (!bus.fim_curso) begin
                        r_state <= FALHA;
                    end else if (!r_req_f && (r_timer == L_MIN_ON)) begin
                        r_state <= FECHADA;
                    end
                end
                FALHA: begin
`ifdef AUTO_REARME_EN
                    if (!r_req_f) begin
                        r_state <= FECHADA;
                    end
`else
                    r_state <= FALHA;
`endif
                end
                default: r_state <= FECHADA;
            endcase
        end
    end

    assign bus.valvula = (r_state == ABRINDO) || (r_state == ABERTA);
    assign bus.aberta  = (r_state == ABERTA);
    assign bus.falha   = (r_state == FALHA);
    assign bus.estado  = r_state;
endmodule

// File: tb/tb_atuador_valvula_agua.sv
// tb/tb_atuador_valvula_agua.sv - scoreboard bench for atuador_valvula_agua with directed per-cycle vectors
`timescale 1ns/1ps
module tb_atuador_valvula_agua;
    localparam logic [1:0] F  = 2'b00;
    localparam logic [1:0] AB = 2'b01;
    localparam logic [1:0] AO = 2'b10;
    localparam logic [1:0] FL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;
    logic [1:0] exp_q[$];

    atuador_valvula_agua_if bus ();

    atuador_valvula_agua #(
        .DEB_CYCLES(4), .OPEN_TIMEOUT(16), .MIN_ON(8), .CW(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic req, input logic fim, input logic [1:0] exp_st);
        bus.S_req     = req;
        bus.fim_curso = fim;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_st);
    endtask

    task automatic cycn(input int n, input logic req, input logic fim, input logic [1:0] exp_st);
        for (int i = 0; i < n; i++) cyc(req, fim, exp_st);
    endtask

    task automatic rst_cyc(input logic req);
        rst = 1'b1;
        cyc(req, 1'b0, F);
        rst = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents a fresh registered status word.
    initial begin
        logic [1:0] e;
        logic [4:0] exp_v;
        logic [4:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                exp_v = {(e == AB) || (e == AO), e == AO, e == FL, e};
                act_v = {bus.valvula, bus.aberta, bus.falha, bus.estado};
                step++;
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL step%0d {valvula,aberta,falha,estado} actual=%b required=%b",
                             step, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.S_req     = 1'b0;
        bus.fim_curso = 1'b0;
        // reset state
        rst_cyc(1'b0);
        rst_cyc(1'b0);

        // glitch of 3 samples is rejected
        cycn(3, 1'b1, 1'b0, F);
        cycn(5, 1'b0, 1'b0, F);

        // normal cycle
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cycn(4, 1'b1, 1'b0, AB);
        cyc(1'b1, 1'b1, AO);
        cycn(19, 1'b1, 1'b1, AO);
        cycn(4, 1'b0, 1'b1, AO);
        cyc(1'b0, 1'b1, F);
        cycn(2, 1'b0, 1'b0, F);

        // minimum on-time: request dropped as aberta rises
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cyc(1'b1, 1'b1, AO);
        cycn(8, 1'b0, 1'b1, AO);
        cyc(1'b0, 1'b1, F);
        cyc(1'b0, 1'b0, F);

        // request drop and limit-switch rise together in ABRINDO
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cycn(4, 1'b0, 1'b0, AB);
        cyc(1'b0, 1'b1, F);

        // reset at ABRINDO timer=7, then full debounce again
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cycn(7, 1'b1, 1'b0, AB);
        rst_cyc(1'b1);
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cycn(4, 1'b0, 1'b0, AB);
        cyc(1'b0, 1'b0, F);

        // limit-switch loss mid-ABERTA
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cycn(4, 1'b1, 1'b1, AO);
        cyc(1'b1, 1'b0, FL);
        cycn(4, 1'b0, 1'b0, FL);
`ifdef AUTO_REARME_EN
        cycn(2, 1'b0, 1'b0, F);
`else
        cycn(2, 1'b0, 1'b0, FL);
`endif
        rst_cyc(1'b0);

        // limit-switch loss coincident with the close condition
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
        cyc(1'b1, 1'b1, AO);
        cycn(8, 1'b0, 1'b1, AO);
        cyc(1'b0, 1'b0, FL);
        rst_cyc(1'b0);

        // open timeout: 16 cycles of drive, then fault
        cycn(4, 1'b1, 1'b0, F);
        cycn(16, 1'b1, 1'b0, AB);
        cyc(1'b1, 1'b0, FL);
`ifdef AUTO_REARME_EN
        cycn(4, 1'b0, 1'b0, FL);
        cycn(2, 1'b0, 1'b0, F);
        cycn(4, 1'b1, 1'b0, F);
        cyc(1'b1, 1'b0, AB);
`else
        cycn(6, 1'b0, 1'b0, FL);
        cycn(6, 1'b1, 1'b0, FL);
        cycn(6, 1'b0, 1'b0, FL);
`endif
        rst_cyc(1'b0);
        cyc(1'b0, 1'b0, F);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/atuador_valvula_agua.md
# atuador_valvula_agua

Valve-actuator controller for the water-flow subsystem. It takes the single-bit flow request produced by the combinational flow-control logic and turns it into a timed valve drive. It debounces the request, confirms opening through a limit switch, and enforces a minimum open time. It latches a fault when the valve fails to open or loses its open position, and returns registered drive and status signals.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive stable samples needed to accept a change of S_req (≥2)
- OPEN_TIMEOUT, 16: maximum cycles allowed in ABRINDO without fim_curso (≥2)
- MIN_ON, 8: minimum cycles the valve stays in ABERTA before it may close (≥1)
- CW, 8: counter width; must hold max(DEB_CYCLES, OPEN_TIMEOUT, MIN_ON)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- S_req  in  1  flow request from the flow-control logic, synchronous to clk
- fim_curso  in  1  valve-open limit switch, 1 = fully open, synchronous, not debounced
- valvula  out  1  valve drive, 1 = energise/open
- aberta  out  1  valve confirmed open
- falha  out  1  fault latched
- estado  out  2  FSM state: 00 FECHADA, 01 ABRINDO, 10 ABERTA, 11 FALHA

## Operation
Reset:
- On rst sampled high, state goes to FECHADA.
- req_f, the debounce counter and the state timer all go to 0.
- All outputs go to 0 and estado goes to 00.
- rst overrides everything, including reset mid-operation in any state.

Debounce:
- req_f is the internal filtered request.
- Each edge where S_req == req_f clears the debounce counter.
- Each edge where S_req != req_f increments it.
- On the edge where the counter is DEB_CYCLES-1 and S_req still differs, req_f takes S_req and the counter clears.
- This applies to both edges of S_req.

FSM (Moore; outputs decoded from registered state):
- FECHADA: valvula=0.
  - req_f=1 → ABRINDO; timer cleared.
- ABRINDO: valvula=1. Transition priority, highest first:
  - req_f=0 → FECHADA.
  - fim_curso=1 → ABERTA; timer cleared.
  - timer==OPEN_TIMEOUT-1 → FALHA.
  - Otherwise timer increments.
- ABERTA: valvula=1, aberta=1. Timer increments, saturating at MIN_ON. Transition priority, highest first:
  - fim_curso=0 → FALHA.
  - req_f=0 and timer==MIN_ON → FECHADA.
- FALHA: valvula=0, falha=1.
  - Exit is governed by the Configuration section.

Arithmetic:
- All counters are unsigned CW-bit.
- The ABERTA timer saturates.
- The ABRINDO timer never reaches wrap-around because the timeout fires first.

## Timing
- S_req rise first sampled at edge k and held:
  - req_f=1 after edge k+DEB_CYCLES-1.
  - valvula=1 after edge k+DEB_CYCLES.
- Glitch shorter than DEB_CYCLES samples: no state change.
- fim_curso sampled high in ABRINDO: aberta=1 after that same edge (1-cycle latency).
- Timeout: valvula stays high exactly OPEN_TIMEOUT cycles in ABRINDO, then falha=1 and valvula=0 from the next cycle.
- Minimum open time: the valve stays in ABERTA at least MIN_ON+1 cycles.
- Closing:
  - Close occurs on the first edge with req_f=0 and saturated timer.
  - valvula=0 the cycle after that edge.
- Simultaneous events:
  - req_f drop plus fim_curso rise in ABRINDO → FECHADA.
  - fim_curso loss plus close condition in ABERTA → FALHA.

## Configuration
- Macro AUTO_REARME_EN.
- Defined:
  - FALHA → FECHADA on an edge where req_f==0.
  - falha clears with that transition.
  - A new request then re-arms normally.
- Undefined:
  - FALHA is terminal; only rst clears it.
  - S_req activity is ignored, but debounce still tracks req_f.

## Test plan
- Glitch rejection:
  - Stimulus: S_req high 3 cycles then low.
  - Response: valvula, aberta and falha stay 0; estado stays 00.
- Normal cycle:
  - Stimulus: S_req held high; fim_curso raised 5 cycles after valvula rises; S_req dropped after 20 cycles in ABERTA.
  - Response: valvula=1 four cycles after S_req.
  - Response: aberta=1 one edge after fim_curso.
  - Response: valvula=0 five edges after the S_req drop (4 debounce edges plus 1).
- Minimum on-time:
  - Stimulus: S_req dropped on the cycle aberta rises.
  - Response: valvula stays 1 until the ABERTA timer reaches 8, i.e. 9 cycles in ABERTA.
- Open timeout:
  - Stimulus: fim_curso held 0.
  - Response: after 16 cycles of valvula=1, falha=1, valvula=0, estado=11.
  - Response: without AUTO_REARME_EN, the state persists through S_req toggles.
- Limit-switch loss:
  - Stimulus: fim_curso dropped mid-ABERTA.
  - Response: FALHA after that edge.
  - Response with AUTO_REARME_EN: falha clears once req_f=0.
- Reset mid-ABRINDO:
  - Stimulus: rst pulsed 1 cycle at ABRINDO timer=7.
  - Response: all outputs 0 and estado=00 after that edge.
  - Response: the next open sequence again takes the full 4-cycle debounce.
